vx_gbar_hier_unit: RTL and testbench
====================================

// Module: vx_gbar_hier_unit
// PURPOSE
//  Cluster-level global barrier unit with configurable socket, core and barrier counts, and an optional uplink.
//  It accepts barrier arrivals from NUM_SOCKETS socket ports through a round-robin arbiter.
//  It tracks per-barrier arrivals by core and releases the barrier locally, or forwards it to an upper-level barrier when HIER=1.
//  It sits beside the cluster L2 and replaces the flat single-port gbar arb+unit pair.
// PARAMETERS
//  NUM_SOCKETS   4   socket request ports
//  CORES_PER_SKT 4   cores per socket; NC = NUM_SOCKETS*CORES_PER_SKT
//  NUM_BARRIERS  8   barrier ids; IDW = clog2(NUM_BARRIERS)
//  HIER          0   1: forward locally complete barriers on the uplink
//  CLUSTER_ID    0   constant driven on up_req_cluster
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 asynchronous, active-high
//  req_valid      in   NUM_SOCKETS       per-socket arrival valid
//  req_id         in   NUM_SOCKETS*IDW   barrier id
//  req_size_m1    in   NUM_SOCKETS*clog2(NC)  local participants-1
//  req_core       in   NUM_SOCKETS*clog2(CORES_PER_SKT)  core within socket
//  req_ready      out  NUM_SOCKETS       arrival accepted (valid&ready)
//  rsp_valid      out  1                 release pulse
//  rsp_mask       out  NUM_BARRIERS      barriers released this cycle
//  up_req_valid   out  1                 uplink arrival (HIER=1)
//  up_req_id      out  IDW               uplink barrier id
//  up_req_cluster out  32                CLUSTER_ID
//  up_req_ready   in   1                 uplink accept
//  up_rsp_valid   in   1                 uplink release
//  up_rsp_id      in   IDW               uplink released id
//  dup_err        out  1                 sticky duplicate-arrival flag
// BEHAVIOUR
//  - Reset values: all outputs 0, arbiter pointer 0, all barriers COLLECT with cleared mask and count. Reset mid-epoch discards arrivals and uplink state.
//  - Per-barrier state machine:
//    - COLLECT -> (HIER=0) COLLECT on completion, releasing the barrier.
//    - COLLECT -> UP_PEND (HIER=1) on completion.
//    - UP_PEND -> UP_WAIT on up_req handshake.
//    - UP_WAIT -> COLLECT on up_rsp_valid with matching id.
//  - Arbiter:
//    - Eligible sockets are those with req_valid whose req_id barrier is in COLLECT.
//    - Round-robin picks one per cycle. Its req_ready=1; all others are 0. The pointer advances past the winner.
//    - Requests to a barrier in UP_PEND/UP_WAIT see req_ready=0 until it returns to COLLECT.
//  - Accept:
//    - Global core index g = socket*CORES_PER_SKT+core.
//    - If mask[g] is already set: the arrival is consumed, its state unchanged, and dup_err is set (sticky until reset).
//    - Otherwise set mask[g] and count++ (width clog2(NC)+1).
//    - Completion occurs when the new count == size_m1+1; size_m1 is taken from the completing request.
//    - On completion, mask and count clear in the same edge.
//  - Release:
//    - rsp_valid/rsp_mask are registered, 1 cycle after the completing accept (HIER=0) or after up_rsp_valid (HIER=1).
//    - rsp_mask may have several bits set.
//    - rsp_valid=0 implies rsp_mask=0.
//  - Uplink:
//    - Lowest-index barrier in UP_PEND drives up_req_*.
//    - valid/id are held stable until ready.
//    - up_rsp for a barrier not in UP_WAIT is ignored.
//    - In the same cycle, an up_rsp for barrier A and an up_req handshake for barrier B are both honoured.
//  - Boundaries:
//    - size_m1=0 completes on the first arrival.
//    - size_m1 >= NC never completes locally; this is a software error and is not flagged.
//    - Arrival and release on the same barrier in one cycle cannot occur, because the completing arrival is itself the release.
//  - HIER=0: up_req_valid tied 0; up_rsp ignored.
// TESTING
//  1. HIER=0, barrier 3, size_m1=3; cores 0,5,9,14 arrive on successive cycles -> rsp_valid with rsp_mask=0x08 exactly 1 cycle after 4th accept; count back to 0.
//  2. All 4 sockets valid on the same cycle for barrier 1 -> accepted one per cycle in order 0,1,2,3, then 1,2,3,0 in the next round; each req_ready one-hot.
//  3. Core 5 arrives twice on barrier 2, size_m1=1 -> dup_err=1, no release; core 6 arrives -> release mask=0x04.
//  4. HIER=1, barrier 0 completes; hold up_req_ready=0 for 5 cycles -> up_req stable, new barrier-0 requests stalled; ready=1 then up_rsp id 0 -> rsp_mask=0x01 next cycle.
//  5. HIER=1: barrier 2 local completion and up_rsp for barrier 5 in the same cycle -> barrier 2 enters UP_PEND and rsp_mask=0x20.
//  6. Assert reset with 2 arrivals pending on barrier 4 -> outputs 0 immediately; after reset, 4 fresh arrivals with size_m1=3 are required for release.

Source files
------------

// File: rtl/vx_gbar_hier_unit.sv
// Cluster-level global barrier unit: round-robin arrival arbitration over socket ports,
// per-barrier core tracking, and local release or uplink forwarding (HIER=1).
module vx_gbar_hier_unit #(
    parameter int NUM_SOCKETS   = 4,
    parameter int CORES_PER_SKT = 4,
    parameter int NUM_BARRIERS  = 8,
    parameter int HIER          = 0,
    parameter int CLUSTER_ID    = 0,
    localparam int NC  = NUM_SOCKETS * CORES_PER_SKT,
    localparam int IDW = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int SW  = (NC > 1) ? $clog2(NC) : 1,
    localparam int CW  = (CORES_PER_SKT > 1) ? $clog2(CORES_PER_SKT) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SOCKETS-1:0]     req_valid,
    input  logic [NUM_SOCKETS*IDW-1:0] req_id,
    input  logic [NUM_SOCKETS*SW-1:0]  req_size_m1,
    input  logic [NUM_SOCKETS*CW-1:0]  req_core,
    output logic [NUM_SOCKETS-1:0]     req_ready,
    output logic                       rsp_valid,
    output logic [NUM_BARRIERS-1:0]    rsp_mask,
    output logic                       up_req_valid,
    output logic [IDW-1:0]             up_req_id,
    output logic [31:0]                up_req_cluster,
    input  logic                       up_req_ready,
    input  logic                       up_rsp_valid,
    input  logic [IDW-1:0]             up_rsp_id,
    output logic                       dup_err
);
    localparam int PW   = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1;
    localparam int CNTW = SW + 1;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] UP_PEND = 2'd1;
    localparam logic [1:0] UP_WAIT = 2'd2;

    logic [1:0]            state_q [NUM_BARRIERS];
    logic [1:0]            state_d [NUM_BARRIERS];
    logic [NC-1:0]         mask_q  [NUM_BARRIERS];
    logic [NC-1:0]         mask_d  [NUM_BARRIERS];
    logic [CNTW-1:0]       cnt_q   [NUM_BARRIERS];
    logic [CNTW-1:0]       cnt_d   [NUM_BARRIERS];
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  rsp_valid_q;
    logic [NUM_BARRIERS-1:0] rsp_mask_q, rsp_mask_d;
    logic                  up_valid_q, up_valid_d;
    logic [IDW-1:0]        up_id_q, up_id_d;
    logic                  dup_q, dup_d;

    logic [IDW-1:0]        sk_id   [NUM_SOCKETS];
    logic [SW-1:0]         sk_size [NUM_SOCKETS];
    logic [CW-1:0]         sk_core [NUM_SOCKETS];
    logic [NUM_SOCKETS-1:0] sk_elig;
    logic                  win_vld;
    logic [PW-1:0]         win_s;

    // A socket is eligible only while its target barrier is collecting arrivals.
    always_comb begin
        for (int unsigned s = 0; s < NUM_SOCKETS; s++) begin
            sk_id[s]   = req_id[s*IDW +: IDW];
            sk_size[s] = req_size_m1[s*SW +: SW];
            sk_core[s] = req_core[s*CW +: CW];
            sk_elig[s] = req_valid[s] && (state_q[sk_id[s]] == COLLECT);
        end
    end

    always_comb begin
        int unsigned s;
        s       = 0;
        win_vld = 1'b0;
        win_s   = '0;
        for (int unsigned k = 0; k < NUM_SOCKETS; k++) begin
            s = (32'(ptr_q) + k) % NUM_SOCKETS;
            if (!win_vld && sk_elig[PW'(s)]) begin
                win_vld = 1'b1;
                win_s   = PW'(s);
            end
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < NUM_SOCKETS; s++) begin
            req_ready[s] = win_vld && (win_s == PW'(s));
        end
    end

    always_comb begin
        logic [IDW-1:0]  a_id;
        logic [SW-1:0]   a_g;
        logic [CNTW-1:0] a_cnt;
        state_d    = state_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        rsp_mask_d = '0;
        dup_d      = dup_q;
        ptr_d      = ptr_q;
        up_valid_d = up_valid_q;
        up_id_d    = up_id_q;
        a_id       = sk_id[win_s];
        a_g        = SW'(32'(win_s) * CORES_PER_SKT + 32'(sk_core[win_s]));
        a_cnt      = cnt_q[a_id] + CNTW'(1);

        // Uplink release and uplink handshake always target different barriers.
        if (HIER != 0 && up_rsp_valid && state_q[up_rsp_id] == UP_WAIT) begin
            state_d[up_rsp_id]    = COLLECT;
            rsp_mask_d[up_rsp_id] = 1'b1;
        end
        if (HIER != 0 && up_valid_q && up_req_ready) begin
            state_d[up_id_q] = UP_WAIT;
        end

        if (win_vld) begin
            ptr_d = (win_s == PW'(NUM_SOCKETS - 1)) ? '0 : win_s + 1'b1;
            if (mask_q[a_id][a_g]) begin
                dup_d = 1'b1;
            end else if (a_cnt == ({1'b0, sk_size[win_s]} + CNTW'(1))) begin
                mask_d[a_id] = '0;
                cnt_d[a_id]  = '0;
                if (HIER != 0) begin
                    state_d[a_id] = UP_PEND;
                end else begin
                    rsp_mask_d[a_id] = 1'b1;
                end
            end else begin
                mask_d[a_id][a_g] = 1'b1;
                cnt_d[a_id]       = a_cnt;
            end
        end

        // The uplink slot holds its barrier until accepted, then picks the lowest pending one.
        if (HIER == 0) begin
            up_valid_d = 1'b0;
            up_id_d    = '0;
        end else if (!up_valid_q || up_req_ready) begin
            up_valid_d = 1'b0;
            up_id_d    = '0;
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                if (!up_valid_d && state_d[b] == UP_PEND) begin
                    up_valid_d = 1'b1;
                    up_id_d    = IDW'(b);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= COLLECT;
                mask_q[b]  <= '0;
                cnt_q[b]   <= '0;
            end
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_mask_q  <= '0;
            up_valid_q  <= 1'b0;
            up_id_q     <= '0;
            dup_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= |rsp_mask_d;
            rsp_mask_q  <= rsp_mask_d;
            up_valid_q  <= up_valid_d;
            up_id_q     <= up_id_d;
            dup_q       <= dup_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_mask       = rsp_mask_q;
    assign up_req_valid   = up_valid_q;
    assign up_req_id      = up_id_q;
    assign up_req_cluster = 32'(CLUSTER_ID);
    assign dup_err        = dup_q;

endmodule

// File: tb/tb_vx_gbar_hier_unit.sv
// Bench for vx_gbar_hier_unit: a flat (HIER=0) and a hierarchical (HIER=1) instance share
// stimulus and are compared every cycle against a set-based barrier model.
module tb_vx_gbar_hier_unit;
    localparam int NS  = 4;
    localparam int CPS = 4;
    localparam int NB  = 8;
    localparam int IDW = 3;
    localparam int SW  = 4;
    localparam int CW  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [NS-1:0]     req_valid;
    logic [NS*IDW-1:0] req_id;
    logic [NS*SW-1:0]  req_size_m1;
    logic [NS*CW-1:0]  req_core;
    logic              up_req_ready, up_rsp_valid;
    logic [IDW-1:0]    up_rsp_id;

    logic [NS-1:0]  req_ready0, req_ready1;
    logic           rsp_valid0, rsp_valid1, up_req_valid0, up_req_valid1, dup_err0, dup_err1;
    logic [NB-1:0]  rsp_mask0, rsp_mask1;
    logic [IDW-1:0] up_req_id0, up_req_id1;
    logic [31:0]    up_req_cluster0, up_req_cluster1;

    logic [NS-1:0]  tv;
    logic [IDW-1:0] tid   [NS];
    logic [SW-1:0]  tsz   [NS];
    logic [CW-1:0]  tcore [NS];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 collecting, 1 waiting for uplink slot, 2 waiting for uplink release.
    int            ph    [2][NB];
    logic [15:0]   arr   [2][NB];
    int            mptr  [2];
    bit            mupv  [2];
    int            mupid [2];
    bit            mdup  [2];
    logic [NB-1:0] mrsp  [2];
    logic [NS-1:0] rdy_seen [2];

    always #5 clk = ~clk;

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            req_valid[s]            = tv[s];
            req_id[s*IDW +: IDW]    = tid[s];
            req_size_m1[s*SW +: SW] = tsz[s];
            req_core[s*CW +: CW]    = tcore[s];
        end
    end

    vx_gbar_hier_unit #(.NUM_SOCKETS(NS), .CORES_PER_SKT(CPS), .NUM_BARRIERS(NB),
                        .HIER(0), .CLUSTER_ID(0)) u_flat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_id(req_id), .req_size_m1(req_size_m1), .req_core(req_core),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_mask(rsp_mask0),
        .up_req_valid(up_req_valid0), .up_req_id(up_req_id0), .up_req_cluster(up_req_cluster0),
        .up_req_ready(up_req_ready), .up_rsp_valid(up_rsp_valid), .up_rsp_id(up_rsp_id),
        .dup_err(dup_err0)
    );

    vx_gbar_hier_unit #(.NUM_SOCKETS(NS), .CORES_PER_SKT(CPS), .NUM_BARRIERS(NB),
                        .HIER(1), .CLUSTER_ID(5)) u_hier (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_id(req_id), .req_size_m1(req_size_m1), .req_core(req_core),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_mask(rsp_mask1),
        .up_req_valid(up_req_valid1), .up_req_id(up_req_id1), .up_req_cluster(up_req_cluster1),
        .up_req_ready(up_req_ready), .up_rsp_valid(up_rsp_valid), .up_rsp_id(up_rsp_id),
        .dup_err(dup_err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_req();
        tv = '0;
        for (int s = 0; s < NS; s++) begin
            tid[s] = '0; tsz[s] = '0; tcore[s] = '0;
        end
    endtask

    task automatic put(input int s, input int id, input int sz, input int core);
        tv[s] = 1'b1; tid[s] = 3'(id); tsz[s] = 4'(sz); tcore[s] = 2'(core);
    endtask

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            for (int b = 0; b < NB; b++) begin
                ph[h][b] = 0; arr[h][b] = '0;
            end
            mptr[h] = 0; mupv[h] = 1'b0; mupid[h] = 0; mdup[h] = 1'b0; mrsp[h] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_rsp_valid0", 32'(rsp_valid0), 0);
        check("rst_rsp_mask0", 32'(rsp_mask0), 0);
        check("rst_dup_err0", 32'(dup_err0), 0);
        check("rst_rsp_valid1", 32'(rsp_valid1), 0);
        check("rst_rsp_mask1", 32'(rsp_mask1), 0);
        check("rst_up_valid1", 32'(up_req_valid1), 0);
        check("rst_up_id1", 32'(up_req_id1), 0);
        check("rst_dup_err1", 32'(dup_err1), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: compare all outputs at the falling edge, then advance the model.
    task automatic step();
        @(negedge clk);
        for (int h = 0; h < 2; h++) begin
            logic [NS-1:0] o_rdy;
            logic [NB-1:0] nxt;
            int w;
            o_rdy = (h == 1) ? req_ready1 : req_ready0;
            w = -1;
            for (int k = 0; k < NS; k++) begin
                int s = (mptr[h] + k) % NS;
                if (w < 0 && tv[s] && ph[h][tid[s]] == 0) w = s;
            end
            rdy_seen[h] = o_rdy;
            check($sformatf("req_ready[%0d]", h), 32'(o_rdy), (w >= 0) ? (32'd1 << w) : 32'd0);
            check($sformatf("rsp_valid[%0d]", h), 32'((h == 1) ? rsp_valid1 : rsp_valid0), 32'(mrsp[h] != 0));
            check($sformatf("rsp_mask[%0d]", h), 32'((h == 1) ? rsp_mask1 : rsp_mask0), 32'(mrsp[h]));
            check($sformatf("up_valid[%0d]", h), 32'((h == 1) ? up_req_valid1 : up_req_valid0), 32'(mupv[h]));
            check($sformatf("up_id[%0d]", h), 32'((h == 1) ? up_req_id1 : up_req_id0), 32'(mupid[h]));
            check($sformatf("cluster[%0d]", h), (h == 1) ? up_req_cluster1 : up_req_cluster0, (h == 1) ? 5 : 0);
            check($sformatf("dup_err[%0d]", h), 32'((h == 1) ? dup_err1 : dup_err0), 32'(mdup[h]));

            nxt = '0;
            if (h == 1 && up_rsp_valid && ph[h][up_rsp_id] == 2) begin
                ph[h][up_rsp_id] = 0;
                nxt[up_rsp_id] = 1'b1;
            end
            if (h == 1 && mupv[h] && up_req_ready) begin
                ph[h][mupid[h]] = 2;
                mupv[h] = 1'b0;
            end
            if (w >= 0) begin
                int id = int'(tid[w]);
                int g  = w * CPS + int'(tcore[w]);
                if (arr[h][id][g]) begin
                    mdup[h] = 1'b1;
                end else begin
                    arr[h][id][g] = 1'b1;
                    if ($countones(arr[h][id]) == int'(tsz[w]) + 1) begin
                        arr[h][id] = '0;
                        if (h == 1) ph[h][id] = 1;
                        else nxt[id] = 1'b1;
                    end
                end
                mptr[h] = (w + 1) % NS;
            end
            if (h == 1 && !mupv[h]) begin
                mupid[h] = 0;
                for (int b = NB - 1; b >= 0; b--) begin
                    if (ph[h][b] == 1) begin
                        mupv[h] = 1'b1;
                        mupid[h] = b;
                    end
                end
            end
            mrsp[h] = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int gl [4];
        int ord;
        logic [NS-1:0] pend;
        clear_req();
        up_req_ready = 1'b0; up_rsp_valid = 1'b0; up_rsp_id = '0;
        model_reset();
        #1;
        do_reset();

        // Barrier 3, four arrivals from different sockets.
        gl = '{0, 5, 9, 14};
        for (int i = 0; i < 4; i++) begin
            clear_req();
            put(gl[i] / CPS, 3, 3, gl[i] % CPS);
            step();
            check("t1_ready", 32'(rdy_seen[0]), 32'd1 << (gl[i] / CPS));
            if (i < 3) check("t1_no_rsp", 32'(rsp_valid0), 0);
        end
        check("t1_rsp_valid", 32'(rsp_valid0), 1);
        check("t1_rsp_mask", 32'(rsp_mask0), 32'h08);
        check("t1_up_valid", 32'(up_req_valid1), 1);
        check("t1_up_id", 32'(up_req_id1), 3);
        clear_req();
        step();
        check("t1_rsp_pulse", 32'(rsp_valid0), 0);

        // Round-robin fairness with all sockets contending for barrier 1.
        do_reset();
        pend = '1;
        for (int i = 0; i < 4; i++) begin
            clear_req();
            for (int s = 0; s < NS; s++) if (pend[s]) put(s, 1, 15, 0);
            step();
            check("t2_order_a", 32'(rdy_seen[0]), 32'd1 << i);
            pend[i] = 1'b0;
        end
        clear_req();
        put(0, 1, 15, 2);
        step();
        pend = '1;
        for (int i = 0; i < 4; i++) begin
            clear_req();
            for (int s = 0; s < NS; s++) if (pend[s]) put(s, 1, 15, 1);
            step();
            ord = (i + 1) % NS;
            check("t2_order_b", 32'(rdy_seen[0]), 32'd1 << ord);
            pend[ord] = 1'b0;
        end

        // Duplicate arrival on barrier 2.
        do_reset();
        clear_req(); put(1, 2, 1, 1); step();
        step();
        check("t3_dup", 32'(dup_err0), 1);
        check("t3_no_rsp", 32'(rsp_valid0), 0);
        clear_req(); put(1, 2, 1, 2); step();
        check("t3_rsp_mask", 32'(rsp_mask0), 32'h04);
        check("t3_dup_sticky", 32'(dup_err0), 1);

        // Uplink back-pressure on barrier 0.
        do_reset();
        clear_req(); put(0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            clear_req(); put(2, 0, 0, 3);
            step();
            check("t4_stall_ready", 32'(rdy_seen[1]), 0);
            check("t4_up_valid", 32'(up_req_valid1), 1);
            check("t4_up_id", 32'(up_req_id1), 0);
        end
        clear_req(); up_req_ready = 1'b1; step();
        up_req_ready = 1'b0;
        check("t4_up_done", 32'(up_req_valid1), 0);
        up_rsp_valid = 1'b1; up_rsp_id = 3'd0; step();
        up_rsp_valid = 1'b0;
        check("t4_rsp_mask", 32'(rsp_mask1), 32'h01);

        // Uplink release of 5 alongside local completion of 2.
        do_reset();
        clear_req(); put(0, 5, 0, 0); step();
        clear_req(); up_req_ready = 1'b1; step();
        up_req_ready = 1'b0;
        put(1, 2, 0, 0); up_rsp_valid = 1'b1; up_rsp_id = 3'd5; step();
        up_rsp_valid = 1'b0; clear_req();
        check("t5_rsp_mask", 32'(rsp_mask1), 32'h20);
        check("t5_up_valid", 32'(up_req_valid1), 1);
        check("t5_up_id", 32'(up_req_id1), 2);

        // Reset mid-epoch discards partial arrivals.
        do_reset();
        clear_req(); put(0, 4, 3, 0); step();
        clear_req(); put(0, 4, 3, 1); step();
        clear_req(); put(0, 4, 3, 0); step();
        check("t6_dup_pre", 32'(dup_err0), 1);
        clear_req();
        #2;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_req(); put(0, 4, 3, c); step();
            if (c < 3) check("t6_no_rsp", 32'(rsp_valid0), 0);
        end
        check("t6_rsp_mask", 32'(rsp_mask0), 32'h10);
        check("t6_dup_clear", 32'(dup_err0), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int cand [$];
            for (int s = 0; s < NS; s++) begin
                tv[s]    = ($urandom_range(0, 9) < 6);
                tid[s]   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                tsz[s]   = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                tcore[s] = 2'($urandom_range(0, 3));
            end
            up_req_ready = 1'($urandom_range(0, 1));
            up_rsp_valid = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < NB; b++) if (ph[1][b] == 2) cand.push_back(b);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                up_rsp_id = 3'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                up_rsp_id = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
